// File: rtl/adc128s022_scan.sv
// Scan controller for the ADC128S022 8-channel 12-bit SPI ADC: runs one frame
// per channel with pipelined addressing and keeps the latest result per channel.
module adc128s022_scan #(
    parameter int CLK_DIV = 8,
    parameter int NUM_CH  = 8
) (
    input  logic        clock_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic        cont,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic        busy,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_saddr,
    input  logic        adc_sdat
);

    generate
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("adc128s022_scan: NUM_CH must be in 1..8");
        end
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("adc128s022_scan: CLK_DIV must be at least 2");
        end
    endgenerate

    localparam int               DIV_W         = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] LP_HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LP_GAP_LAST   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [2:0]       LP_LAST_FRAME = 3'(NUM_CH - 1);
    localparam logic [3:0]       LP_NUM_CH     = 4'(NUM_CH);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_half;      // 0: SCLK low half, 1: SCLK high half
    logic [3:0]       r_bit;
    logic [2:0]       r_frame;
    logic             r_init;      // current frame is the post-reset dummy frame
    logic [10:0]      r_shift;
    logic             r_cs_n;
    logic             r_sclk;
    logic             r_saddr;
    logic             r_busy;
    logic             r_valid;
    logic [2:0]       r_sample_ch;
    logic [11:0]      r_sample_data;
    logic [11:0]      r_bank [0:7];
    logic [11:0]      r_rd_data;

    logic [2:0]       w_addr;
    logic             w_last_frame;
    logic [3:0]       w_next_bit;
    logic             w_next_din;
    logic [11:0]      w_result;

    // Frame i addresses channel i+1 so its conversion lands in frame i+1;
    // the last frame wraps to channel 0 to prime the next scan.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through this block can leave a value held (no latch).
        w_addr       = 3'd0;
        w_last_frame = r_init || (r_frame == LP_LAST_FRAME);
        if (!r_init && (r_frame != LP_LAST_FRAME)) begin
            w_addr = r_frame + 3'd1;
        end
        w_next_bit = r_bit + 4'd1;
        case (w_next_bit)
            4'd2:    w_next_din = w_addr[2];
            4'd3:    w_next_din = w_addr[1];
            4'd4:    w_next_din = w_addr[0];
            default: w_next_din = 1'b0;
        endcase
        w_result = {r_shift, adc_sdat};
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_INIT;
            r_div         <= '0;
            r_half        <= 1'b0;
            r_bit         <= 4'd0;
            r_frame       <= 3'd0;
            r_init        <= 1'b0;
            r_shift       <= '0;
            r_cs_n        <= 1'b1;
            r_sclk        <= 1'b1;
            r_saddr       <= 1'b0;
            r_busy        <= 1'b1;
            r_valid       <= 1'b0;
            r_sample_ch   <= 3'd0;
            r_sample_data <= 12'd0;
            r_rd_data     <= 12'd0;
            // NOTE: the bank is eight flop words that must read back as 0
            // after reset, so it is reset here rather than left as RAM.
            for (int i = 0; i < 8; i++) begin
                r_bank[i] <= 12'd0;
            end
        end else begin
            r_valid   <= 1'b0;
            r_rd_data <= ({1'b0, rd_ch} < LP_NUM_CH) ? r_bank[rd_ch] : 12'd0;

            case (r_state)
                ST_INIT: begin
                    r_state <= ST_SETUP;
                    r_init  <= 1'b1;
                    r_cs_n  <= 1'b0;
                    r_div   <= '0;
                end

                ST_IDLE: begin
                    if (start || cont) begin
                        r_state <= ST_SETUP;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                    end
                end

                ST_SETUP: begin
                    if (r_div == LP_HALF_LAST) begin
                        r_state <= ST_SHIFT;
                        r_div   <= '0;
                        r_half  <= 1'b0;
                        r_bit   <= 4'd0;
                        r_frame <= 3'd0;
                        r_sclk  <= 1'b0;
                        r_saddr <= 1'b0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (r_div != LP_HALF_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else if (!r_half) begin
                        r_div  <= '0;
                        r_half <= 1'b1;
                        r_sclk <= 1'b1;
                    end else begin
                        // Last cycle of the high half: DOUT is sampled here.
                        r_div   <= '0;
                        r_half  <= 1'b0;
                        r_shift <= {r_shift[9:0], adc_sdat};
                        if (r_bit != 4'd15) begin
                            r_bit   <= w_next_bit;
                            r_sclk  <= 1'b0;
                            r_saddr <= w_next_din;
                        end else begin
                            r_bit <= 4'd0;
                            if (!r_init) begin
                                r_valid         <= 1'b1;
                                r_sample_ch     <= r_frame;
                                r_sample_data   <= w_result;
                                r_bank[r_frame] <= w_result;
                            end
                            if (w_last_frame) begin
                                r_state <= ST_GAP;
                                r_cs_n  <= 1'b1;
                                r_saddr <= 1'b0;
                            end else begin
                                r_frame <= r_frame + 3'd1;
                                r_sclk  <= 1'b0;
                                r_saddr <= 1'b0;
                            end
                        end
                    end
                end

                ST_GAP: begin
                    if (r_div == LP_GAP_LAST) begin
                        r_div <= '0;
                        if (cont && !r_init) begin
                            r_state <= ST_SETUP;
                            r_cs_n  <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_init  <= 1'b0;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign rd_data      = r_rd_data;
    assign busy         = r_busy;
    assign sample_valid = r_valid;
    assign sample_ch    = r_sample_ch;
    assign sample_data  = r_sample_data;
    assign adc_cs_n     = r_cs_n;
    assign adc_sclk     = r_sclk;
    assign adc_saddr    = r_saddr;

endmodule

// File: doc/adc128s022_scan.md
# adc128s022_scan

Parametrised scan controller for the DE0-Nano's on-board ADC128S022 8-channel, 12-bit SPI ADC. It drives `adc_cs_n`, `adc_sclk` and `adc_saddr`, samples `adc_sdat`, and converts channels 0..NUM_CH-1 either once per `start` or continuously. Each result is emitted as a one-cycle valid strobe, and the latest result per channel is held in a register bank readable by the rest of the top-level design.

## Interface
- `CLK_DIV`, default 8: `clock_50` cycles per SCLK half-period. SCLK = 50 MHz / (2·CLK_DIV). Must be ≥ 2.
- `NUM_CH`, default 8: channels scanned, 0..NUM_CH-1. Must be in 1..8; anything else is an elaboration error.
- `clock_50`, in, 1: sole clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request one scan. Sampled only in IDLE.
- `cont`, in, 1: continuous mode. Sampled in IDLE and at the end of GAP.
- `rd_ch`, in, 3: channel select for the readback bank.
- `rd_data`, out, 12: readback value for `rd_ch`, registered.
- `busy`, out, 1: controller not in IDLE.
- `sample_valid`, out, 1: one-cycle strobe when a result is ready.
- `sample_ch`, out, 3: channel of the current result.
- `sample_data`, out, 12: current result.
- `adc_cs_n`, out, 1: ADC chip select.
- `adc_sclk`, out, 1: ADC clock. Idles high.
- `adc_saddr`, out, 1: ADC DIN.
- `adc_sdat`, in, 1: ADC DOUT.

## Operation
- **States:** INIT, IDLE, SETUP, SHIFT, GAP.
- **Reset values:**
  - `adc_cs_n`=1, `adc_sclk`=1, `adc_saddr`=0.
  - `sample_valid`=0, `sample_ch`=0, `sample_data`=0, `rd_data`=0, all bank entries 0.
  - `busy`=1; state INIT.
- **INIT:** after reset release, run one dummy frame (SETUP → SHIFT → GAP) that addresses channel 0. It produces no `sample_valid` and no bank write. Then go to IDLE and drop `busy`. This forces the ADC's address pipeline to a known state.
- **IDLE:**
  - `start`=1 or `cont`=1 launches a scan: go to SETUP and drive `adc_cs_n` low.
  - `start` while busy is ignored; it is not queued.
- **SETUP:** CLK_DIV cycles, SCLK high, CS low.
- **SHIFT:** NUM_CH back-to-back 16-bit frames; CS stays low across all frames of a scan.
  - Each bit b (0..15) lasts 2·CLK_DIV cycles: SCLK low for the first half, high for the second.
  - `adc_saddr` updates at the start of the low half. It carries ADD2/ADD1/ADD0 for b=2/3/4 and 0 for all other bits.
  - `adc_sdat` is sampled on the last cycle of each high half. Bits b=4..15 form the result, MSB first.
- **Address pipelining:**
  - Frame i (0..NUM_CH-1) sends address (i+1) mod NUM_CH, so the last frame of each scan addresses channel 0.
  - Frame i's result belongs to channel i.
- **Result:** one cycle after frame i's final sample:
  - `sample_valid`=1, `sample_ch`=i, `sample_data`=result.
  - `bank[i]` is written in the same cycle.
  - `sample_ch`/`sample_data` hold until the next valid. There is no backpressure.
- **GAP:** after the final frame, CS high, SCLK high, `adc_saddr` 0, for 2·CLK_DIV cycles. Then:
  - `cont`=1 → SETUP (next scan);
  - otherwise → IDLE.
  - Deasserting `cont` mid-scan lets the current scan complete.
- **Readback:** `rd_data` ← `bank[rd_ch]` every cycle. For `rd_ch` ≥ NUM_CH it returns 0.
- **NUM_CH=1:** every frame addresses channel 0.
- **Reset mid-frame:** all outputs return to reset values immediately (asynchronously), and INIT runs again after release.

## Timing
- Frame length: 32·CLK_DIV cycles. SCLK period: 2·CLK_DIV cycles, 50% duty.
- The `start` sampling cycle is t0:
  - `adc_cs_n` falls at t0+1;
  - first SCLK falling edge at t0+1+CLK_DIV;
  - frame i's `sample_valid` at t0+1+CLK_DIV+32·CLK_DIV·(i+1).
- `busy` rises at t0+1 and falls on the cycle `adc_cs_n`'s GAP ends.
- Continuous mode: scan period = CLK_DIV + 32·CLK_DIV·NUM_CH + 2·CLK_DIV cycles.
- `rd_data` latency: 1 cycle from `rd_ch` or from the bank write.
- `adc_cs_n`, `adc_sclk` and `adc_saddr` are registered outputs with no combinational paths.

## Test plan
- **Init frame:** release reset → one CS-low window of 33·CLK_DIV cycles with `adc_saddr` 0 throughout, no `sample_valid`; `busy` goes 1→0; then `start` is accepted.
- **Single scan:** CLK_DIV=8, NUM_CH=8, ADC model returns 0x100+ch → 8 strobes spaced 256 cycles apart, first at t0+1+264, with `sample_ch` 0..7 and data 0x100..0x107. DIN addresses observed are 1,2,…,7,0.
- **Readback:** after the single scan, `rd_ch`=5 → `rd_data`=0x105 one cycle later; `rd_ch`=7 with NUM_CH=4 → 0.
- **Continuous:** NUM_CH=3, `cont`=1 for 2.5 scans, then 0 → exactly 3 complete scans (9 strobes), GAP of 16 cycles between scans, then IDLE.
- **Busy start:** `start` pulsed mid-scan → ignored, no extra scan.
- **Reset mid-frame:** assert `reset_n`=0 at bit 7 of frame 2 → CS/SCLK go high immediately, no strobe; after release, INIT frame repeats and a following scan returns correct channel/data pairing.
